// File: rtl/uart_rx_pkg.sv
// Shared definitions for the uart_rx receiver: frame geometry, FSM state
// encoding and the baud counter width, plus a helper that derives the
// start-bit midpoint offset from the bit period.
// Ports: none (package).
package uart_rx_pkg;

    // Payload bits per 8N1 frame.
    localparam int DATA_BITS = 8;

    // Baud counter width; bit periods up to 65535 cycles fit.
    localparam int CNT_W = 16;

    // Receiver FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Terminal count for the half-period tick: the start bit is sampled
    // bit_cycles/2 cycles (integer division) after the falling edge is seen.
    function automatic logic [CNT_W-1:0] half_last(input int bit_cycles);
        return CNT_W'(bit_cycles / 2 - 1);
    endfunction

    // Terminal count for the full-period tick.
    function automatic logic [CNT_W-1:0] full_last(input int bit_cycles);
        return CNT_W'(bit_cycles - 1);
    endfunction

endpackage

// File: rtl/uart_rx_baud_cnt.sv
// Purpose: bit-period timer for uart_rx; flags the half-period and full-period points.
// Latency: ticks are combinational decodes of the registered count (count 0 = first cycle after clear).
// Backpressure: none; free-running while clear is low, held at zero while clear is high.
//
// Ports:
//   clock     - rising-edge clock
//   reset     - asynchronous active-high reset, clears the count
//   clear     - synchronous clear; count restarts at 0 on the next edge
//   half_tick - high in the cycle the count equals uart_clock_bit/2 - 1
//   full_tick - high in the cycle the count equals uart_clock_bit - 1
module uart_rx_baud_cnt
    import uart_rx_pkg::*;
#(
    parameter int uart_clock_bit = 5208
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic half_tick,
    output logic full_tick
);

    localparam logic [CNT_W-1:0] HALF_LAST = half_last(uart_clock_bit);
    localparam logic [CNT_W-1:0] FULL_LAST = full_last(uart_clock_bit);

    logic [CNT_W-1:0] count;

    // Reload to zero on the terminal count rather than relying on natural
    // 16-bit rollover, so the period is exact for every legal setting.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || (count == FULL_LAST)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign half_tick = (count == HALF_LAST);
    assign full_tick = (count == FULL_LAST);

endmodule

// File: rtl/uart_rx.sv
// Purpose: 8N1 UART receiver; samples each bit at its midpoint and presents the byte with a one-cycle done strobe.
// Latency: done rises one cycle after the stop-bit midpoint edge (~9.5 bit periods after the start edge), +2 cycles with UART_RX_SYNC_EN.
// Backpressure: none; readdata is overwritten by the next good frame, so the consumer must capture it on done.
//
// Ports:
//   clock    - rising-edge clock
//   reset    - asynchronous active-high reset
//   rx       - serial line, idles high
//   readdata - last byte received with a valid stop bit; changes only when done pulses
//   done     - one-cycle pulse when readdata holds a newly received byte
//
// Build option: define UART_RX_SYNC_EN to pass rx through a two-flop
// synchronizer (resets to the idle level) before the FSM. Every sample point
// and done move exactly two cycles later; data is unaffected.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int uart_clock_bit = 5208
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] readdata,
    output logic       done
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic                 rx_line;
    uart_state_e          state;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 frame_err;
    logic                 baud_clear;
    logic                 half_tick;
    logic                 full_tick;

`ifdef UART_RX_SYNC_EN
    // Two-flop synchronizer. Reset value 1 matches the idle line so that
    // leaving reset never looks like a start bit.
    logic [1:0] rx_sync;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_sync <= 2'b11;
        end else begin
            rx_sync <= {rx_sync[0], rx};
        end
    end

    assign rx_line = rx_sync[1];
`else
    assign rx_line = rx;
`endif

    // Timer restarts on the edge that detects the start bit (state still
    // IDLE) and again at the start-bit midpoint, so every later full-period
    // tick lands on a bit midpoint.
    assign baud_clear = (state == IDLE) || ((state == START) && half_tick);

    uart_rx_baud_cnt #(
        .uart_clock_bit(uart_clock_bit)
    ) u_baud_cnt (
        .clock     (clock),
        .reset     (reset),
        .clear     (baud_clear),
        .half_tick (half_tick),
        .full_tick (full_tick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
            readdata  <= 8'h00;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_line) begin
                        state   <= START;
                        bit_cnt <= '0;
                    end
                end

                START: begin
                    // A line that is high again at the midpoint was a glitch.
                    if (half_tick) begin
                        state <= rx_line ? IDLE : DATA;
                    end
                end

                DATA: begin
                    // LSB arrives first: shifting in from the top leaves
                    // sample k in bit k after all eight samples.
                    if (full_tick) begin
                        shreg <= {rx_line, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end

                STOP: begin
                    if (frame_err) begin
                        // Bad stop bit: hold off until the line returns
                        // high so a long break is not mistaken for a start.
                        if (rx_line) begin
                            frame_err <= 1'b0;
                            state     <= IDLE;
                        end
                    end else if (full_tick) begin
                        if (rx_line) begin
                            readdata <= shreg;
                            done     <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: the driver pushes the byte and the exact
// done cycle for every frame expected to complete; a negedge monitor pops and
// compares on each done and otherwise checks that readdata holds.
module tb_uart_rx;

    // Short bit period keeps the run small; odd value exercises the
    // integer-division midpoint (41/2 = 20).
    localparam int B    = 41;
    localparam int HALF = B / 2;
`ifdef UART_RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    typedef struct {
        logic [7:0] data;
        int         at;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] readdata;
    logic       done;

    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] model_rd = 8'h00;
    bit         mon_en = 1'b0;
    exp_t       expq[$];
    exp_t       mon_e;

    uart_rx #(
        .uart_clock_bit(B)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .rx       (rx),
        .readdata (readdata),
        .done     (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %02h, want %02h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int want);
        vectors++;
        if (act != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    // Called aligned (#1 after a posedge). Drives a full frame; the line is
    // left high and aligned again on return, so back-to-back calls produce
    // a start bit immediately after a full-length stop bit.
    task automatic send_byte(input logic [7:0] d, input logic stop, input bit expect_done);
        rx = 1'b0;
        // Start edge is seen at posedge cyc+1; stop midpoint is HALF + 9*B later.
        if (expect_done) expq.push_back(exp_t'{data: d, at: cyc + 1 + HALF + 9 * B + SYNC_LAT});
        for (int i = 0; i < 8; i++) begin
            repeat (B) @(posedge clock);
            #1 rx = d[i];
        end
        repeat (B) @(posedge clock);
        #1 rx = stop;
        repeat (B) @(posedge clock);
        #1 rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Monitor: every done must match the oldest pending frame, both in data
    // and in cycle; with no done, readdata must hold the last good byte.
    always @(negedge clock) begin
        if (mon_en && !reset) begin
            if (done === 1'b1) begin
                if (expq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: readdata=%02h at cycle %0d, none pending", readdata, cyc);
                end else begin
                    mon_e = expq.pop_front();
                    check8("done_readdata", readdata, mon_e.data);
                    check_int("done_cycle", cyc, mon_e.at);
                    model_rd = mon_e.data;
                end
            end else begin
                check8("readdata_hold", readdata, model_rd);
            end
        end
    end

    initial begin
        logic [7:0] burst [5];
        burst[0] = 8'hAA;
        burst[1] = 8'hAB;
        burst[2] = 8'hAC;
        burst[3] = 8'hAD;
        burst[4] = 8'hAF;

        reset = 1'b1;
        rx    = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check8("reset_readdata", readdata, 8'h00);
        check8("reset_done", {7'd0, done}, 8'h00);
        reset  = 1'b0;
        mon_en = 1'b1;
        idle(2);

        // Back-to-back burst.
        foreach (burst[i]) send_byte(burst[i], 1'b1, 1'b1);
        idle(5);

        // Short low glitch while idle: rejected at the start-bit midpoint.
        rx = 1'b0;
        idle(10);
        rx = 1'b1;
        idle(3 * B);
        check8("glitch_hold", readdata, 8'hAF);
        send_byte(8'h55, 1'b1, 1'b1);
        idle(5);

        // Framing error: stop bit low for a full bit, then line recovers.
        send_byte(8'h3C, 1'b0, 1'b0);
        idle(B);
        check8("ferr_hold", readdata, 8'h55);
        send_byte(8'hC3, 1'b1, 1'b1);
        idle(5);

        // Reset in the middle of data bit 4 of 8'hFF.
        fork
            send_byte(8'hFF, 1'b1, 1'b0);
            begin
                repeat (5 * B + HALF) @(posedge clock);
                #2 reset = 1'b1;
                model_rd = 8'h00;
                repeat (2) @(posedge clock);
                #2 reset = 1'b0;
            end
        join
        check8("post_reset_readdata", readdata, 8'h00);
        idle(5);
        send_byte(8'h81, 1'b1, 1'b1);

        // Let any outstanding done arrive, bounded.
        for (int n = 0; n < 20 * B && expq.size() != 0; n++) @(posedge clock);
        check_int("pending_frames", expq.size(), 0);
        idle(2 * B);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter uart_clock_bit, default 5208, meaning clock cycles per bit (50 MHz / 9600 baud); legal range 4..65535; first positional parameter.
REQ-002 SHALL have port clock  input  1  sole clock, rising-edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port rx  input  1  serial line, idle high.
REQ-005 SHALL have port readdata  output  8  last received byte.
REQ-006 SHALL have port done  output  1  one-cycle pulse when a valid byte is available.
REQ-007 SHALL use positional port order clock, reset, rx, readdata, done.

Function
REQ-008 SHALL receive frame format 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), no parity.
REQ-009 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-010 IDLE: rx==0 sampled -> START, bit counter cleared.
REQ-011 START: after uart_clock_bit/2 cycles (integer division), rx sampled; 0 -> DATA, 1 -> IDLE (glitch rejection, no done).
REQ-012 DATA: rx sampled every uart_clock_bit cycles from the start-bit midpoint; sample k (k=0..7) shifted into internal bit k; after 8th sample -> STOP.
REQ-013 STOP: rx sampled uart_clock_bit cycles after the 8th data sample; if 1, readdata loaded with the shifted byte and done=1 for exactly one cycle; go to IDLE.
REQ-014 STOP with rx==0 (framing error): no done, readdata unchanged; FSM waits in STOP until rx==1, then IDLE.
REQ-015 done SHALL be 0 at all other times, including during start and data bits.
REQ-016 readdata SHALL change only in the cycle done asserts; held stable otherwise.
REQ-017 done latency: registered, asserted within 1 cycle of the stop-bit midpoint (~uart_clock_bit*9.5 cycles after the start-bit falling edge), i.e. inside the stop-bit window.
REQ-018 Back-to-back frames (next start bit immediately after a full stop bit) SHALL be received without loss.
REQ-019 Baud counter SHALL be 16 bits, reload-on-terminal, with no wrap-around side effects.

Reset
REQ-020 reset SHALL asynchronously force state IDLE, counters 0, shift register 0, readdata 8'h00, done 0.
REQ-021 Reset mid-frame SHALL abort the frame with no done; after release, reception resumes from IDLE.

Configuration
REQ-022 Macro UART_RX_SYNC_EN defined: rx passes through a two-flop synchronizer (reset value 1) before the FSM, adding exactly 2 cycles to all sample points and done.
REQ-023 Macro UART_RX_SYNC_EN undefined: rx used directly by the FSM; no added latency.

Structure
REQ-024 Package uart_rx_pkg SHALL hold the state enum typedef and the constant DATA_BITS=8.
REQ-025 A sub-module uart_rx_baud_cnt (half/full-period tick generator, parameterised by uart_clock_bit) is natural; FSM and shift register stay in uart_rx.

Verification
REQ-026 Reset 2 cycles, idle 2 cycles; send 8'hAA, 8'hAB, 8'hAC, 8'hAD, 8'hAF at 5208 cycles/bit -> each: done=0 during data bits, exactly one done pulse in the stop-bit window, readdata equals the sent byte.
REQ-027 rx low pulse of 1000 cycles while idle -> no done, readdata unchanged, next byte 8'h55 received correctly.
REQ-028 Frame 8'h3C with stop bit driven 0 -> no done, readdata retains previous value; after rx high, 8'hC3 received with a single done.
REQ-029 reset asserted at data bit 4 of 8'hFF -> done never asserts, readdata=8'h00; next frame 8'h81 received correctly.
REQ-030 Run scenario REQ-026 with and without UART_RX_SYNC_EN -> identical data; done shifted by exactly 2 cycles when the macro is defined.
